ext_bus_ctrl: RTL and testbench

- Sequences the AS2650 core's external multiplexed 8-bit address/data bus.
- Turns a single-beat core request (read or write, 16-bit address) into the bus phases in this order:
  - latch high address byte (le_hi)
  - latch low address byte (le_lo)
  - data phase (oeb or web)
- Remembers the last latched high address byte and skips the le_hi phase when it has not changed.
- Sits between the core and the mprj_io pad mapping (bus[7:0], le_lo, le_hi, OEb, WEb).

---
 rtl/ext_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ext_bus_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_ctrl.sv
// External multiplexed address/data bus sequencer for the AS2650 core.
// Emits le_hi / le_lo / data phases per access and caches the last high address byte.
module ext_bus_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          HI_CACHE    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        hi_inval,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic        bus_oeb,
    output logic        le_hi,
    output logic        le_lo,
    output logic        oeb,
    output logic        web
);

    typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, DATA} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t      state, state_nxt;
    logic        acc_we;
    logic [15:0] acc_addr;
    logic [7:0]  acc_wdata;
    logic [7:0]  cache_hi;
    logic        cache_valid;
    logic [3:0]  wait_cnt;

    logic        accept, hit, last_data;
    logic        eff_we;
    logic [15:0] eff_addr;
    logic [7:0]  eff_wdata;

    logic        le_hi_nxt, le_lo_nxt, oeb_nxt, web_nxt, bus_oeb_nxt, ack_nxt, busy_nxt;
    logic [7:0]  bus_out_nxt, rdata_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            le_hi   <= 1'b0;
            le_lo   <= 1'b0;
            oeb     <= 1'b1;
            web     <= 1'b1;
            bus_oeb <= 1'b1;
            bus_out <= 8'h00;
            ack     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            state   <= state_nxt;
            le_hi   <= le_hi_nxt;
            le_lo   <= le_lo_nxt;
            oeb     <= oeb_nxt;
            web     <= web_nxt;
            bus_oeb <= bus_oeb_nxt;
            bus_out <= bus_out_nxt;
            ack     <= ack_nxt;
            busy    <= busy_nxt;
            rdata   <= rdata_nxt;
        end
    end

    // An invalidate landing on the ADDR_HI edge loses to the refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_we      <= 1'b0;
            acc_addr    <= 16'h0000;
            acc_wdata   <= 8'h00;
            cache_hi    <= 8'h00;
            cache_valid <= 1'b0;
            wait_cnt    <= 4'd0;
        end else begin
            if (accept) begin
                acc_we    <= we;
                acc_addr  <= addr;
                acc_wdata <= wdata;
            end
            if (state == ADDR_HI) begin
                cache_hi    <= acc_addr[15:8];
                cache_valid <= 1'b1;
            end else if (hi_inval) begin
                cache_valid <= 1'b0;
            end
            if (state == ADDR_LO) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == DATA && !last_data) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // busy still set in IDLE marks the ack cycle, where a held req is ignored.
    always_comb begin
        accept    = (state == IDLE) && !busy && req;
        hit       = HI_CACHE && cache_valid && !hi_inval && (addr[15:8] == cache_hi);
        last_data = (wait_cnt == 4'd0);
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = hit ? ADDR_LO : ADDR_HI;
            ADDR_HI: state_nxt = ADDR_LO;
            ADDR_LO: state_nxt = DATA;
            DATA:    if (last_data) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eff_we      = (state == IDLE) ? we    : acc_we;
        eff_addr    = (state == IDLE) ? addr  : acc_addr;
        eff_wdata   = (state == IDLE) ? wdata : acc_wdata;
        le_hi_nxt   = 1'b0;
        le_lo_nxt   = 1'b0;
        oeb_nxt     = 1'b1;
        web_nxt     = 1'b1;
        bus_oeb_nxt = 1'b1;
        bus_out_nxt = bus_out;
        ack_nxt     = 1'b0;
        busy_nxt    = busy;
        rdata_nxt   = rdata;
        case (state_nxt)
            ADDR_HI: begin
                le_hi_nxt   = 1'b1;
                bus_oeb_nxt = 1'b0;
                bus_out_nxt = eff_addr[15:8];
            end
            ADDR_LO: begin
                le_lo_nxt   = 1'b1;
                bus_oeb_nxt = 1'b0;
                bus_out_nxt = eff_addr[7:0];
            end
            DATA: begin
                if (eff_we) begin
                    web_nxt     = 1'b0;
                    bus_oeb_nxt = 1'b0;
                    bus_out_nxt = eff_wdata;
                end else begin
                    oeb_nxt = 1'b0;
                end
            end
            default: ;
        endcase
        if (accept) begin
            busy_nxt = 1'b1;
        end else if (state == IDLE) begin
            busy_nxt = 1'b0;
        end
        if (state == DATA && last_data) begin
            ack_nxt = 1'b1;
            if (!acc_we) rdata_nxt = bus_in;
        end
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Testbench for ext_bus_ctrl: two instances (0 and 2 wait states) driven from a vector table,
// hand-written reset sequence and randomized accesses checked against a phase-list model.
module tb_ext_bus_ctrl;

    // Control vector order: {le_hi, le_lo, oeb, web, bus_oeb, ack, busy}
    localparam logic [6:0] CTRL_IDLE = 7'b0011100;
    localparam logic [6:0] CTRL_HI   = 7'b1011001;
    localparam logic [6:0] CTRL_LO   = 7'b0111001;
    localparam logic [6:0] CTRL_RD   = 7'b0001101;
    localparam logic [6:0] CTRL_WR   = 7'b0010001;
    localparam logic [6:0] CTRL_ACK  = 7'b0011111;

    typedef struct {
        int          d;
        logic        w;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  bin_early;
        logic [7:0]  bin_late;
        logic        pre_inv;
        logic        acc_inv;
        logic        exp_miss;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we_i, hi_inval;
    logic [1:0]  ack, busy, bus_oeb, le_hi, le_lo, oeb, web;
    logic [15:0] addr_i [2];
    logic [7:0]  wdata_i [2];
    logic [7:0]  bus_in_i [2];
    logic [7:0]  rdata [2];
    logic [7:0]  bus_out [2];

    int checks = 0;
    int errors = 0;

    logic [1:0]  m_valid;
    logic [7:0]  m_hi [2];
    logic [7:0]  m_rdata [2];

    vec_t vecs [10];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ext_bus_ctrl #(
            .WAIT_STATES((g == 0) ? 0 : 2),
            .HI_CACHE(1'b1)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .req(req[g]),
            .we(we_i[g]),
            .addr(addr_i[g]),
            .wdata(wdata_i[g]),
            .hi_inval(hi_inval[g]),
            .ack(ack[g]),
            .rdata(rdata[g]),
            .busy(busy[g]),
            .bus_in(bus_in_i[g]),
            .bus_out(bus_out[g]),
            .bus_oeb(bus_oeb[g]),
            .le_hi(le_hi[g]),
            .le_lo(le_lo[g]),
            .oeb(oeb[g]),
            .web(web[g])
        );
    end

    function automatic logic [6:0] ctrl_of(input int d);
        return {le_hi[d], le_lo[d], oeb[d], web[d], bus_oeb[d], ack[d], busy[d]};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pulseInval(input int d);
        hi_inval[d] = 1'b1;
        @(negedge clk);
        hi_inval[d] = 1'b0;
        checkOutput($sformatf("d%0d inval idle ctrl", d), 16'(ctrl_of(d)), 16'(CTRL_IDLE));
        m_valid[d] = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; walks the expected phase list cycle by cycle.
    task automatic applyStimulus(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd,
                                 input logic [7:0] bin_early, input logic [7:0] bin_late,
                                 input logic acc_inv, input logic mid_inv,
                                 input logic exp_miss, input logic [7:0] exp_rdata);
        int ws;
        int first_data;
        int last_k;
        ws         = (d == 0) ? 0 : 2;
        first_data = exp_miss ? 3 : 2;
        last_k     = first_data + ws;
        req[d]      = 1'b1;
        we_i[d]     = w;
        addr_i[d]   = a;
        wdata_i[d]  = wd;
        bus_in_i[d] = bin_early;
        hi_inval[d] = acc_inv;
        for (int k = 1; k <= last_k + 1; k++) begin
            @(negedge clk);
            hi_inval[d] = (k == 1) ? mid_inv : 1'b0;
            if (k < first_data) begin
                if (exp_miss && k == 1) begin
                    checkOutput($sformatf("d%0d %h c%0d hi ctrl", d, a, k), 16'(ctrl_of(d)), 16'(CTRL_HI));
                    checkOutput($sformatf("d%0d %h c%0d hi bus", d, a, k), 16'(bus_out[d]), 16'(a[15:8]));
                end else begin
                    checkOutput($sformatf("d%0d %h c%0d lo ctrl", d, a, k), 16'(ctrl_of(d)), 16'(CTRL_LO));
                    checkOutput($sformatf("d%0d %h c%0d lo bus", d, a, k), 16'(bus_out[d]), 16'(a[7:0]));
                end
            end else if (k <= last_k) begin
                if (w) begin
                    checkOutput($sformatf("d%0d %h c%0d wr ctrl", d, a, k), 16'(ctrl_of(d)), 16'(CTRL_WR));
                    checkOutput($sformatf("d%0d %h c%0d wr bus", d, a, k), 16'(bus_out[d]), 16'(wd));
                end else begin
                    checkOutput($sformatf("d%0d %h c%0d rd ctrl", d, a, k), 16'(ctrl_of(d)), 16'(CTRL_RD));
                end
                if (k == last_k) bus_in_i[d] = bin_late;
            end else begin
                checkOutput($sformatf("d%0d %h ack ctrl", d, a), 16'(ctrl_of(d)), 16'(CTRL_ACK));
                checkOutput($sformatf("d%0d %h rdata", d, a), 16'(rdata[d]), 16'(exp_rdata));
                checkOutput($sformatf("d%0d %h held bus", d, a), 16'(bus_out[d]), 16'(w ? wd : a[7:0]));
            end
        end
        @(negedge clk);
        checkOutput($sformatf("d%0d %h post-ack idle", d, a), 16'(ctrl_of(d)), 16'(CTRL_IDLE));
        req[d]     = 1'b0;
        m_valid[d] = !(mid_inv && !exp_miss);
        m_hi[d]    = a[15:8];
        m_rdata[d] = exp_rdata;
    endtask

    initial begin
        logic [7:0]  hi_set [4];
        int          d;
        logic        w, acc_inv, mid_inv, miss;
        logic [15:0] a;
        logic [7:0]  wd, be, bl, er;

        vecs[0] = '{0, 1'b0, 16'h0000, 8'h00, 8'h04, 8'h04, 1'b0, 1'b0, 1'b1, 8'h04};
        vecs[1] = '{0, 1'b0, 16'h0001, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A};
        vecs[2] = '{0, 1'b1, 16'h00FF, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A};
        vecs[3] = '{0, 1'b0, 16'h0100, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{0, 1'b0, 16'h0102, 8'h00, 8'h66, 8'h66, 1'b1, 1'b0, 1'b1, 8'h66};
        vecs[5] = '{0, 1'b0, 16'h0103, 8'h00, 8'h67, 8'h67, 1'b0, 1'b1, 1'b1, 8'h67};
        vecs[6] = '{0, 1'b0, 16'h0104, 8'h00, 8'h68, 8'h68, 1'b0, 1'b0, 1'b0, 8'h68};
        vecs[7] = '{1, 1'b0, 16'h1234, 8'h00, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[8] = '{1, 1'b1, 16'h1256, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22};
        vecs[9] = '{1, 1'b0, 16'h12FF, 8'h00, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99};
        hi_set = '{8'h00, 8'h01, 8'h7F, 8'hFF};

        rst_n    = 1'b0;
        req      = 2'b00;
        we_i     = 2'b00;
        hi_inval = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_i[i]   = 16'h0000;
            wdata_i[i]  = 8'h00;
            bus_in_i[i] = 8'h00;
            m_hi[i]     = 8'h00;
            m_rdata[i]  = 8'h00;
        end
        m_valid = 2'b00;

        #12;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("d%0d reset ctrl", i), 16'(ctrl_of(i)), 16'(CTRL_IDLE));
            checkOutput($sformatf("d%0d reset bus", i), 16'(bus_out[i]), 16'h0000);
            checkOutput($sformatf("d%0d reset rdata", i), 16'(rdata[i]), 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].pre_inv) pulseInval(vecs[i].d);
            applyStimulus(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].bin_early,
                          vecs[i].bin_late, vecs[i].acc_inv, 1'b0, vecs[i].exp_miss, vecs[i].exp_rdata);
        end

        // Reset during the data phase of a write (cache hit on 0x01xx).
        req[0]     = 1'b1;
        we_i[0]    = 1'b1;
        addr_i[0]  = 16'h0110;
        wdata_i[0] = 8'h77;
        @(negedge clk);
        checkOutput("rst seq lo ctrl", 16'(ctrl_of(0)), 16'(CTRL_LO));
        @(negedge clk);
        checkOutput("rst seq wr ctrl", 16'(ctrl_of(0)), 16'(CTRL_WR));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst async ctrl", 16'(ctrl_of(0)), 16'(CTRL_IDLE));
        checkOutput("rst async bus", 16'(bus_out[0]), 16'h0000);
        checkOutput("rst async rdata", 16'(rdata[0]), 16'h0000);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("rst no ack", 16'(ctrl_of(0)), 16'(CTRL_IDLE));
        rst_n   = 1'b1;
        m_valid = 2'b00;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        @(negedge clk);
        applyStimulus(0, 1'b0, 16'h0130, 8'h00, 8'h4E, 8'h4E, 1'b0, 1'b0, 1'b1, 8'h4E);

        for (int it = 0; it < 60; it++) begin
            d       = int'($urandom_range(0, 1));
            w       = 1'($urandom_range(0, 1));
            a       = {hi_set[$urandom_range(0, 3)], 8'($urandom)};
            wd      = 8'($urandom);
            be      = 8'($urandom);
            bl      = 8'($urandom);
            acc_inv = ($urandom_range(0, 7) == 0);
            mid_inv = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) pulseInval(d);
            miss = !m_valid[d] || acc_inv || (m_hi[d] != a[15:8]);
            er   = w ? m_rdata[d] : bl;
            applyStimulus(d, w, a, wd, be, bl, acc_inv, mid_inv, miss, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
